gpio_shift_ctrl: RTL

Hardware sequencer for Arduino-style shiftOut/shiftIn over two GPIO lines (serial clock, serial data), so software no longer bit-bangs pins through the GPIO peripheral. It accepts one byte-command at a time over a valid/ready handshake. It generates a programmable-rate serial clock, shifts data out and samples data in (full duplex), and returns the received byte with a one-cycle response pulse. It sits beside the GPIO block in the peripheral subsystem; pin muxing selects its outputs in place of gpio_out/gpio_dir bits.

---
 rtl/gpio_shift_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/gpio_shift_ctrl.sv
// gpio_shift_ctrl: hardware shiftOut/shiftIn sequencer for two GPIO pads.
// Accepts one command at a time. It drives a programmable-rate serial clock,
// shifts data out on sdo_o and samples sdi_i on the last cycle of each high
// phase. The received word is returned with a one-cycle rsp_valid_o pulse.
//
// state | meaning
// IDLE  | ready for a command, pads parked (sclk=0, sdo=0, oe=0)
// PH_LO | serial clock low for D cycles, current bit on sdo_o
// PH_HI | serial clock high for D cycles, sdi_i sampled on the last one
// DONE  | one-cycle response pulse, then back to IDLE
//
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_dir_i                  0 = shiftOut (drive sdo), 1 = shiftIn
//   cmd_msb_first_i            bit order
//   cmd_data_i                 word to shift out
//   clk_div_i                  serial clock half-period in clk cycles (0 -> 1)
//   sclk_o, sdo_o, sdo_oe_o    pad-side clock, data and data output enable
//   sdi_i                      pad-side data in (already synchronised)
//   busy_o                     transfer in progress
//   rsp_valid_o, rsp_data_o    completion pulse and received word (held)
module gpio_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic             cmd_msb_first_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [DIV_W-1:0] clk_div_i,
  output logic             sclk_o,
  output logic             sdo_o,
  output logic             sdo_oe_o,
  input  logic             sdi_i,
  output logic             busy_o,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PH_LO, PH_HI, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, rx_q, rx_next, rsp_q;
  logic             dir_q, msb_q;
  logic [DIV_W-1:0] div_q, div_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_idx;
  logic             phase_end, last_bit;

  // div_q is never 0, so div_q-1 is the terminal count of every phase.
  assign phase_end = (div_cnt_q == div_q - DIV_W'(1));
  assign last_bit  = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign bit_idx   = msb_q ? (CNT_W'(WIDTH - 1) - bit_cnt_q) : bit_cnt_q;
  assign rx_next   = msb_q ? {rx_q[WIDTH-2:0], sdi_i} : {sdi_i, rx_q[WIDTH-1:1]};
  assign rsp_data_o = rsp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    sclk_o      = 1'b0;
    sdo_o       = 1'b0;
    sdo_oe_o    = ~dir_q;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        sdo_oe_o    = 1'b0;
        if (cmd_valid_i) state_d = PH_LO;
      end
      PH_LO: begin
        sdo_o = data_q[bit_idx];
        if (phase_end) state_d = PH_HI;
      end
      PH_HI: begin
        sclk_o = 1'b1;
        sdo_o  = data_q[bit_idx];
        if (phase_end) state_d = last_bit ? DONE : PH_LO;
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      rx_q      <= '0;
      rsp_q     <= '0;
      dir_q     <= 1'b0;
      msb_q     <= 1'b0;
      div_q     <= DIV_W'(1);
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            data_q    <= cmd_data_i;
            dir_q     <= cmd_dir_i;
            msb_q     <= cmd_msb_first_i;
            div_q     <= (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
            rx_q      <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        PH_LO: begin
          div_cnt_q <= phase_end ? '0 : div_cnt_q + DIV_W'(1);
        end
        PH_HI: begin
          if (phase_end) begin
            div_cnt_q <= '0;
            rx_q      <= rx_next;
            if (last_bit) rsp_q <= rx_next;
            else          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        DONE: begin
          bit_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
